// File: rtl/uart_bit_timer.sv
// Runtime-configurable UART bit timer: mid-bit and end-of-bit strobes plus bit index
// for one frame per accepted start. Divisor and frame format are captured at accept.
//   state | meaning
//   IDLE  | no frame open, waiting for start
//   RUN   | frame open, counting bit cells
module uart_bit_timer #(
  parameter int CNT_W   = 16,
  parameter int DIV_MIN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] baud_div,
  input  logic [1:0]       data_bits,
  input  logic             parity_en,
  input  logic             stop_two,
  output logic             busy,
  output logic             bit_mid,
  output logic             bit_end,
  output logic [3:0]       bit_idx,
  output logic             frame_done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] div_new;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       len_q;
  logic [3:0]       len_new;
  logic             last_bit;

  always_comb begin
    div_new  = (baud_div < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : baud_div;
    len_new  = 4'd7 + {2'b00, data_bits} + {3'b000, parity_en} + {3'b000, stop_two};
    cnt_inc  = cnt + CNT_W'(1);
    last_bit = (bit_idx == (len_q - 4'd1));
  end

  // Strobes are computed one cycle ahead from cnt_inc so they line up with cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      div_q      <= '0;
      len_q      <= '0;
      busy       <= 1'b0;
      bit_mid    <= 1'b0;
      bit_end    <= 1'b0;
      bit_idx    <= '0;
      frame_done <= 1'b0;
    end else begin
      bit_mid    <= 1'b0;
      bit_end    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            div_q   <= div_new;
            len_q   <= len_new;
          end
        end
        RUN: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
          end else if (cnt == div_q) begin
            cnt <= '0;
            if (last_bit) begin
              bit_idx <= '0;
              if (start) begin
                div_q <= div_new;
                len_q <= len_new;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            cnt        <= cnt_inc;
            bit_mid    <= (cnt_inc == (div_q >> 1));
            bit_end    <= (cnt_inc == div_q);
            frame_done <= (cnt_inc == div_q) && last_bit;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bit_timer.sv
// Scoreboard bench for uart_bit_timer: stimulus queues expected strobes with their
// cycle number and bit index; a negedge monitor pops and compares each strobe.
module tb_uart_bit_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] baud_div;
  logic [1:0]  data_bits;
  logic        parity_en;
  logic        stop_two;
  logic        busy;
  logic        bit_mid;
  logic        bit_end;
  logic [3:0]  bit_idx;
  logic        frame_done;

  uart_bit_timer #(.CNT_W(16), .DIV_MIN(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .baud_div(baud_div),
    .data_bits(data_bits), .parity_en(parity_en), .stop_two(stop_two),
    .busy(busy), .bit_mid(bit_mid), .bit_end(bit_end), .bit_idx(bit_idx),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int kind; int cyc; int idx;} ev_t;
  ev_t q[$];
  int  total = 0;
  int  bad   = 0;
  localparam int BIG = 1 << 30;

  // kind: 0 = bit_mid, 1 = bit_end, 2 = frame_done
  function automatic int push_frame(int s, int d, int l, int cut);
    int b;
    for (int i = 0; i < l; i++) begin
      b = s + i * (d + 1);
      if (b + d / 2 < cut) q.push_back('{0, b + d / 2, i});
      if (b + d < cut) begin
        q.push_back('{1, b + d, i});
        if (i == l - 1) q.push_back('{2, b + d, i});
      end
    end
    return s + l * (d + 1);
  endfunction

  task automatic chk_ev(input int k);
    ev_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL ev_unexpected: got kind=%0d cyc=%0d idx=%0d, required no strobe", k, cyc, bit_idx);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.idx != int'(bit_idx)) begin
        bad++;
        $display("FAIL ev: got kind=%0d cyc=%0d idx=%0d, required kind=%0d cyc=%0d idx=%0d",
                 k, cyc, bit_idx, e.kind, e.cyc, e.idx);
      end
    end
  endtask

  always @(negedge clk) begin
    if (bit_mid)    chk_ev(0);
    if (bit_end)    chk_ev(1);
    if (frame_done) chk_ev(2);
  end

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int label);
    while (cyc < label) step();
  endtask

  task automatic set_cfg(input int bd, input int code, input int par, input int stp);
    baud_div  = 16'(bd);
    data_bits = 2'(code);
    parity_en = par[0];
    stop_two  = stp[0];
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout at cyc=%0d, required finish", cyc);
    $fatal(1, "timeout");
  end

  int s, e, s2, e2, a, nb;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    set_cfg(0, 0, 0, 0);
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_mid", bit_mid, 0);
    check("rst_end", bit_end, 0);
    check("rst_done", frame_done, 0);
    check("rst_idx", bit_idx, 0);
    rst = 1'b0;
    step();

    // T1: 8N1 at 9600 bd
    set_cfg(5207, 3, 0, 0);
    start = 1'b1;
    s = cyc + 1;
    e = push_frame(s, 5207, 10, BIG);
    step();
    start = 1'b0;
    check("t1_busy_rise", busy, 1);
    check("t1_idx0", bit_idx, 0);
    run_to(e - 1);
    check("t1_busy_last", busy, 1);
    step();
    check("t1_busy_fall", busy, 0);

    // T2: 7E2, L=11
    set_cfg(433, 2, 1, 1);
    start = 1'b1;
    s = cyc + 1;
    e = push_frame(s, 433, 11, BIG);
    step();
    start = 1'b0;
    run_to(e - 1);
    check("t2_busy_last", busy, 1);
    step();
    check("t2_busy_fall", busy, 0);

    // T3: back-to-back with divisor change mid-frame
    set_cfg(40, 3, 0, 0);
    start = 1'b1;
    s  = cyc + 1;
    s2 = push_frame(s, 40, 10, BIG);
    e2 = push_frame(s2, 20, 10, BIG);
    step();
    run_to(s + 50);
    baud_div = 16'd20;
    run_to(s2 - 1);
    check("t3_busy_done", busy, 1);
    step();
    start = 1'b0;
    check("t3_busy_gap", busy, 1);
    check("t3_idx_restart", bit_idx, 0);
    run_to(e2);
    check("t3_busy_fall", busy, 0);

    // T4a: abort at bit 4, cnt 100
    set_cfg(200, 3, 0, 0);
    start = 1'b1;
    s = cyc + 1;
    a = s + 4 * 201 + 100;
    e = push_frame(s, 200, 10, a + 1);
    step();
    start = 1'b0;
    run_to(a);
    check("t4_idx_before", bit_idx, 4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4_abort_busy", busy, 0);
    check("t4_abort_idx", bit_idx, 0);
    repeat (5) step();

    // T4b: same point, reset instead
    start = 1'b1;
    s = cyc + 1;
    a = s + 4 * 201 + 100;
    e = push_frame(s, 200, 10, a + 1);
    step();
    start = 1'b0;
    run_to(a);
    rst = 1'b1;
    step();
    check("t4_rst_busy", busy, 0);
    check("t4_rst_mid", bit_mid, 0);
    check("t4_rst_end", bit_end, 0);
    check("t4_rst_done", frame_done, 0);
    check("t4_rst_idx", bit_idx, 0);
    rst = 1'b0;
    repeat (3) step();

    // T5: clamp of divisor 0, abort+start in IDLE is accepted
    set_cfg(0, 3, 0, 0);
    start = 1'b1;
    abort = 1'b1;
    s = cyc + 1;
    e = push_frame(s, 2, 10, BIG);
    step();
    start = 1'b0;
    abort = 1'b0;
    check("t5_accept", busy, 1);
    run_to(e);
    check("t5_busy_fall", busy, 0);

    // T5: abort+start in RUN goes idle
    set_cfg(0, 0, 0, 0);
    start = 1'b1;
    s = cyc + 1;
    a = s + 5;
    e = push_frame(s, 2, 7, a + 1);
    step();
    start = 1'b0;
    run_to(a);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    check("t5_abort_prio", busy, 0);
    step();
    check("t5_stay_idle", busy, 0);

    // T6: minimum frame 5N1, D=2
    set_cfg(2, 0, 0, 0);
    start = 1'b1;
    s = cyc + 1;
    e = push_frame(s, 2, 7, BIG);
    step();
    start = 1'b0;
    nb = 0;
    for (int i = 0; i < 25; i++) begin
      if (busy) nb++;
      step();
    end
    check("t6_busy_cycles", nb, 21);

    repeat (3) step();
    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
